// File: rtl/vedic_pkg.sv
// vedic_pkg: shared constants and elaboration helpers
// for the Vedic multiplier family.
package vedic_pkg;

    localparam int MIN_WIDTH = 4;
    localparam int MAX_WIDTH = 32;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/cla_nbit.sv
// cla_nbit: W-bit adder built from per-bit generate/propagate
// terms; the carry out of the top bit is intentionally not exposed.
module cla_nbit #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s
);

    logic [W-1:0] p;
    logic [W-1:0] c;

    assign p = a ^ b;

    // Carry into each bit from generate/propagate of the bit below.
    always_comb begin
        c[0] = cin;
        for (int i = 1; i < W; i++) begin
            c[i] = (a[i-1] & b[i-1]) | (p[i-1] & c[i-1]);
        end
    end

    assign s = p ^ c;

endmodule

// File: rtl/vedic_2bit_mul.sv
// vedic_2bit_mul: 2x2 unsigned Urdhva-Tiryagbhyam leaf,
// vertical and crosswise terms with half-adder carries.
module vedic_2bit_mul (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);

    logic x10;
    logic x01;
    logic hh;
    logic c1;

    assign x10  = a[1] & b[0];
    assign x01  = a[0] & b[1];
    assign hh   = a[1] & b[1];
    assign c1   = x10 & x01;
    assign p[0] = a[0] & b[0];
    assign p[1] = x10 ^ x01;
    assign p[2] = hh ^ c1;
    assign p[3] = hh & c1;

endmodule

// File: rtl/vedic_nbit_core.sv
// vedic_nbit_core: recursive unsigned WxW Vedic multiplier,
// four half-width products merged with two adders.
module vedic_nbit_core #(
    parameter int W = 4
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    if (W == 2) begin : g_leaf
        vedic_2bit_mul u_leaf (
            .a (a),
            .b (b),
            .p (p)
        );
    end else begin : g_node
        localparam int H = W / 2;

        logic [W-1:0]     pll;
        logic [W-1:0]     plh;
        logic [W-1:0]     phl;
        logic [W-1:0]     phh;
        logic [W:0]       mid;
        logic [2*W-H-1:0] hi;

        vedic_nbit_core #(.W(H)) u_ll (
            .a (a[H-1:0]),
            .b (b[H-1:0]),
            .p (pll)
        );
        vedic_nbit_core #(.W(H)) u_lh (
            .a (a[H-1:0]),
            .b (b[W-1:H]),
            .p (plh)
        );
        vedic_nbit_core #(.W(H)) u_hl (
            .a (a[W-1:H]),
            .b (b[H-1:0]),
            .p (phl)
        );
        vedic_nbit_core #(.W(H)) u_hh (
            .a (a[W-1:H]),
            .b (b[W-1:H]),
            .p (phh)
        );

        // Crosswise sum keeps its carry in the extra top bit.
        cla_nbit #(.W(W + 1)) u_mid (
            .a   ({1'b0, plh}),
            .b   ({1'b0, phl}),
            .cin (1'b0),
            .s   (mid)
        );

        // Low H bits of pll pass straight through to the product.
        cla_nbit #(.W(2 * W - H)) u_acc (
            .a   ({phh, pll[W-1:H]}),
            .b   ({{(H - 1){1'b0}}, mid}),
            .cin (1'b0),
            .s   (hi)
        );

        assign p = {hi, pll[H-1:0]};
    end

endmodule

// File: rtl/vedic_nbit_mul_pipe.sv
// vedic_nbit_mul_pipe: 3-stage streaming Vedic multiplier
// with per-transaction sign mode, tag sideband and global stall.
module vedic_nbit_mul_pipe
    import vedic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);

    localparam int H = WIDTH / 2;
    localparam int P = 2 * WIDTH;

    if (!is_pow2(WIDTH) || WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH
        || TAG_W < 1) begin : g_bad_cfg
        $fatal(1, "vedic_nbit_mul_pipe: illegal WIDTH/TAG_W");
    end

    logic             adv;
    logic             v1;
    logic             v2;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             neg1;
    logic             neg2;
    logic [TAG_W-1:0] t1;
    logic [TAG_W-1:0] t2;
    logic [WIDTH-1:0] pll;
    logic [WIDTH-1:0] plh;
    logic [WIDTH-1:0] phl;
    logic [WIDTH-1:0] phh;
    logic [WIDTH-1:0] pll2;
    logic [WIDTH-1:0] plh2;
    logic [WIDTH-1:0] phl2;
    logic [WIDTH-1:0] phh2;
    logic [WIDTH:0]   mid;
    logic [P-H-1:0]   hi;
    logic [P-1:0]     sum;
    logic [P-1:0]     neg_sum;
    logic [P-1:0]     res;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign busy     = v1 | v2 | out_valid;

    // -2^(WIDTH-1) negates to itself, which is its correct magnitude.
    assign mag_a = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
    assign mag_b = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;

    vedic_nbit_core #(.W(H)) u_ll (
        .a (a1[H-1:0]),
        .b (b1[H-1:0]),
        .p (pll)
    );
    vedic_nbit_core #(.W(H)) u_lh (
        .a (a1[H-1:0]),
        .b (b1[WIDTH-1:H]),
        .p (plh)
    );
    vedic_nbit_core #(.W(H)) u_hl (
        .a (a1[WIDTH-1:H]),
        .b (b1[H-1:0]),
        .p (phl)
    );
    vedic_nbit_core #(.W(H)) u_hh (
        .a (a1[WIDTH-1:H]),
        .b (b1[WIDTH-1:H]),
        .p (phh)
    );

    cla_nbit #(.W(WIDTH + 1)) u_mid (
        .a   ({1'b0, plh2}),
        .b   ({1'b0, phl2}),
        .cin (1'b0),
        .s   (mid)
    );

    cla_nbit #(.W(P - H)) u_acc (
        .a   ({phh2, pll2[WIDTH-1:H]}),
        .b   ({{(H - 1){1'b0}}, mid}),
        .cin (1'b0),
        .s   (hi)
    );

    assign sum = {hi, pll2[H-1:0]};

    // Two's-complement negate; a zero magnitude stays zero.
    cla_nbit #(.W(P)) u_neg (
        .a   (~sum),
        .b   ('0),
        .cin (1'b1),
        .s   (neg_sum)
    );

    assign res = neg2 ? neg_sum : sum;

    // Stage valid bits: flush drops everything, else shift on advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
        end else if (flush) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
        end else if (adv) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
        end
    end

    // Stage data moves in lockstep with the valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1      <= '0;
            b1      <= '0;
            neg1    <= 1'b0;
            t1      <= '0;
            pll2    <= '0;
            plh2    <= '0;
            phl2    <= '0;
            phh2    <= '0;
            neg2    <= 1'b0;
            t2      <= '0;
            out_p   <= '0;
            out_tag <= '0;
        end else if (adv) begin
            a1      <= mag_a;
            b1      <= mag_b;
            neg1    <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            t1      <= in_tag;
            pll2    <= pll;
            plh2    <= plh;
            phl2    <= phl;
            phh2    <= phh;
            neg2    <= neg1;
            t2      <= t1;
            out_p   <= res;
            out_tag <= t2;
        end
    end

endmodule

// File: tb/tb_vedic_nbit_mul_pipe.sv
// tb_vedic_nbit_mul_pipe: scenario tasks against a plain-arithmetic
// product model for WIDTH 4, 8 and 16.
module tb_vedic_nbit_mul_pipe;

    typedef struct packed {
        logic [31:0] p;
        logic [3:0]  t;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush;

    logic        in_valid, in_ready, in_signed;
    logic        out_valid, out_ready, busy;
    logic [7:0]  in_a, in_b;
    logic [3:0]  in_tag, out_tag;
    logic [15:0] out_p;

    logic        v4, rdy4, s4, ov4, ordy4, busy4;
    logic [3:0]  a4, b4, t4, ot4;
    logic [7:0]  p4;

    logic        v16, rdy16, s16, ov16, ordy16, busy16;
    logic [15:0] a16, b16;
    logic [3:0]  t16, ot16;
    logic [31:0] p16;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q8[$];
    exp_t q4[$];
    exp_t q16[$];

    vedic_nbit_mul_pipe #(.WIDTH(8), .TAG_W(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    vedic_nbit_mul_pipe #(.WIDTH(4), .TAG_W(4)) u_w4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (v4),
        .in_ready  (rdy4),
        .in_a      (a4),
        .in_b      (b4),
        .in_signed (s4),
        .in_tag    (t4),
        .out_valid (ov4),
        .out_ready (ordy4),
        .out_p     (p4),
        .out_tag   (ot4),
        .busy      (busy4)
    );

    vedic_nbit_mul_pipe #(.WIDTH(16), .TAG_W(4)) u_w16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (v16),
        .in_ready  (rdy16),
        .in_a      (a16),
        .in_b      (b16),
        .in_signed (s16),
        .in_tag    (t16),
        .out_valid (ov16),
        .out_ready (ordy16),
        .out_p     (p16),
        .out_tag   (ot16),
        .busy      (busy16)
    );

    function automatic logic [31:0] ref_mul(input int w,
                                            input logic [15:0] a,
                                            input logic [15:0] b,
                                            input logic s);
        longint sa, sb, m;
        sa = longint'(a);
        sb = longint'(b);
        if (s && a[w-1]) sa -= longint'(1) << w;
        if (s && b[w-1]) sb -= longint'(1) << w;
        m = sa * sb;
        return 32'(m & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic drive8(input logic v, input logic [7:0] a,
                          input logic [7:0] b, input logic s,
                          input logic [3:0] t, input logic rdy);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_tag    = t;
        out_ready = rdy;
        #1;
        if (v && in_ready && !flush)
            q8.push_back('{ref_mul(8, 16'(a), 16'(b), s), t});
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_checks++;
        if (out_p !== 16'h0 || out_tag !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_data: got p=%h tag=%h want 0/0",
                     out_p, out_tag);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [7:0]  ta [4];
        logic [7:0]  tb [4];
        logic        ts [4];
        logic [15:0] tp [4];
        ta = '{8'hFF, 8'h80, 8'hFF, 8'h00};
        tb = '{8'hFF, 8'h80, 8'h7F, 8'h80};
        ts = '{1'b0, 1'b1, 1'b1, 1'b1};
        tp = '{16'hFE01, 16'h4000, 16'hFF81, 16'h0000};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive8(1'b1, ta[k], tb[k], ts[k], 4'(k + 5), 1'b1);
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                if (c == 1) drive8(1'b0, 8'h0, 8'h0, 1'b0, 4'h0, 1'b1);
                n_checks++;
                if (out_valid !== (c == 3)) begin
                    n_fail++;
                    $display("FAIL latency_%0d_cyc%0d: got %b want %b",
                             k, c, out_valid, (c == 3));
                end
            end
            n_checks++;
            if (out_p !== tp[k] || out_tag !== 4'(k + 5)) begin
                n_fail++;
                $display("FAIL directed_%0d: got p=%h tag=%0d want p=%h tag=%0d",
                         k, out_p, out_tag, tp[k], k + 5);
            end
        end
        q8.delete();
    endtask

    task automatic test_back_to_back();
        int   n_low;
        exp_t e;
        n_low = 0;
        q8.delete();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                n_checks++;
                if (out_valid !== (c < 19)) begin
                    n_fail++;
                    $display("FAIL b2b_valid_cyc%0d: got %b want %b",
                             c, out_valid, (c < 19));
                end
                if (out_valid === 1'b1 && q8.size() > 0) begin
                    e = q8.pop_front();
                    n_checks++;
                    if (out_p !== e.p[15:0] || out_tag !== e.t) begin
                        n_fail++;
                        $display("FAIL b2b_data_cyc%0d: got p=%h tag=%0d want p=%h tag=%0d",
                                 c, out_p, out_tag, e.p[15:0], e.t);
                    end
                end
            end
            if (c < 16)
                drive8(1'b1, 8'(c), 8'(15 - c), 1'b0, 4'(c), 1'b1);
            else
                drive8(1'b0, 8'h0, 8'h0, 1'b0, 4'h0, 1'b1);
            if (in_ready !== 1'b1) n_low++;
        end
        n_checks++;
        if (n_low != 0) begin
            n_fail++;
            $display("FAIL b2b_in_ready: got %0d low cycles want 0", n_low);
        end
    endtask

    task automatic test_backpressure();
        int   got;
        exp_t e;
        got = 0;
        q8.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom),
                   4'(c + 9), 1'b1);
        end
        @(negedge clk);
        drive8(1'b0, 8'h0, 8'h0, 1'b0, 4'h0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_ctrl_cyc%0d: got valid=%b ready=%b want 1/0",
                         c, out_valid, in_ready);
            end
            n_checks++;
            if (out_p !== q8[0].p[15:0] || out_tag !== q8[0].t) begin
                n_fail++;
                $display("FAIL stall_hold_cyc%0d: got p=%h tag=%0d want p=%h tag=%0d",
                         c, out_p, out_tag, q8[0].p[15:0], q8[0].t);
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            if (out_valid === 1'b1) begin
                n_checks++;
                if (q8.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_extra: got p=%h want no output", out_p);
                end else begin
                    e = q8.pop_front();
                    got++;
                    if (out_p !== e.p[15:0] || out_tag !== e.t) begin
                        n_fail++;
                        $display("FAIL bp_order_%0d: got p=%h tag=%0d want p=%h tag=%0d",
                                 got, out_p, out_tag, e.p[15:0], e.t);
                    end
                end
            end
            drive8(1'b0, 8'h0, 8'h0, 1'b0, 4'h0, 1'b1);
        end
        n_checks++;
        if (got != 3) begin
            n_fail++;
            $display("FAIL bp_count: got %0d want 3", got);
        end
    endtask

    task automatic test_flush();
        int seen;
        seen = 0;
        q8.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive8(1'b1, 8'($urandom), 8'($urandom), 1'b0, 4'(c), 1'b1);
        end
        @(negedge clk);
        flush = 1'b1;
        drive8(1'b1, 8'h33, 8'h44, 1'b0, 4'hF, 1'b1);
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre: got ready=%b busy=%b want 1/1",
                     in_ready, busy);
        end
        @(negedge clk);
        flush = 1'b0;
        drive8(1'b0, 8'h0, 8'h0, 1'b0, 4'h0, 1'b1);
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clear: got busy=%b valid=%b want 0/0",
                     busy, out_valid);
        end
        q8.delete();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL flush_leak: got %0d outputs want 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive8(1'b1, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)),
                   1'b0, 4'(c), 1'b1);
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: got valid=%b want 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_p !== 16'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: got valid=%b p=%h busy=%b want 0/0/0",
                     out_valid, out_p, busy);
        end
        @(posedge clk);
        drive8(1'b0, 8'h0, 8'h0, 1'b0, 4'h0, 1'b1);
        rst_n = 1'b1;
        q8.delete();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rstmid_leak: got %0d outputs want 0", seen);
        end
    endtask

    task automatic test_random();
        exp_t e;
        logic rdy;
        q8.delete();
        q4.delete();
        q16.delete();
        for (int c = 0; c < 520; c++) begin
            @(negedge clk);
            if (ov4 === 1'b1) begin
                n_checks++;
                e = (q4.size() > 0) ? q4.pop_front() : '1;
                if (p4 !== e.p[7:0] || ot4 !== e.t) begin
                    n_fail++;
                    $display("FAIL rand_w4_cyc%0d: got p=%h tag=%0d want p=%h tag=%0d",
                             c, p4, ot4, e.p[7:0], e.t);
                end
            end
            if (ov16 === 1'b1) begin
                n_checks++;
                e = (q16.size() > 0) ? q16.pop_front() : '1;
                if (p16 !== e.p || ot16 !== e.t) begin
                    n_fail++;
                    $display("FAIL rand_w16_cyc%0d: got p=%h tag=%0d want p=%h tag=%0d",
                             c, p16, ot16, e.p, e.t);
                end
            end
            rdy = (c >= 512) || ($urandom_range(0, 3) != 0);
            if (out_valid === 1'b1) begin
                n_checks++;
                e = (q8.size() > 0) ? q8[0] : '1;
                if (out_p !== e.p[15:0] || out_tag !== e.t) begin
                    n_fail++;
                    $display("FAIL rand_w8_cyc%0d: got p=%h tag=%0d want p=%h tag=%0d",
                             c, out_p, out_tag, e.p[15:0], e.t);
                end
                if (rdy && q8.size() > 0) void'(q8.pop_front());
            end
            v4  = (c < 512);
            a4  = 4'(c);
            b4  = 4'(c >> 4);
            s4  = 1'((c >> 8) & 1);
            t4  = 4'($urandom);
            v16 = (c < 512) && ($urandom_range(0, 3) != 0);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            s16 = 1'($urandom);
            t16 = 4'($urandom);
            drive8((c < 512) && ($urandom_range(0, 3) != 0),
                   8'($urandom), 8'($urandom), 1'($urandom),
                   4'($urandom), rdy);
            if (v4 && rdy4)
                q4.push_back('{ref_mul(4, 16'(a4), 16'(b4), s4), t4});
            if (v16 && rdy16)
                q16.push_back('{ref_mul(16, a16, b16, s16), t16});
        end
        n_checks++;
        if (q4.size() != 0 || q8.size() != 0 || q16.size() != 0) begin
            n_fail++;
            $display("FAIL rand_drain: got left w4=%0d w8=%0d w16=%0d want 0",
                     q4.size(), q8.size(), q16.size());
        end
        n_checks++;
        if (busy4 !== 1'b0 || busy !== 1'b0 || busy16 !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_idle: got busy %b%b%b want 000",
                     busy4, busy, busy16);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_signed = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        v4        = 1'b0;
        a4        = '0;
        b4        = '0;
        s4        = 1'b0;
        t4        = '0;
        ordy4     = 1'b1;
        v16       = 1'b0;
        a16       = '0;
        b16       = '0;
        s16       = 1'b0;
        t16       = '0;
        ordy16    = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
